// File: rtl/taglist_pkg.sv
// Shared constants for the tag-list generator: end-marker codes, FSM states
// and the bit offsets of the packed entry fields.
package taglist_pkg;

  localparam logic [1:0] LE_ELEM    = 2'b00;
  localparam logic [1:0] LE_SKIP    = 2'b01;
  localparam logic [1:0] LE_SEQ_END = 2'b10;
  localparam logic [1:0] LE_ROM_END = 2'b11;

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int FINAL_BIT = 0;
  localparam int LAST_LSB  = 1;

  function automatic int first_lsb(input int pos_w);
    return pos_w + 1;
  endfunction

  function automatic int seq_lsb(input int pos_w);
    return 2 * pos_w + 1;
  endfunction

  function automatic int entry_w(input int pos_w, input int seq_w);
    return seq_w + 2 * pos_w + 1;
  endfunction

endpackage

// File: rtl/taglist_entry_pack.sv
// Combinational packer: {seq, first, last, final} -> one zero-extended RAM word.
module taglist_entry_pack
  import taglist_pkg::*;
#(
  parameter int POS_W  = 10,
  parameter int SEQ_W  = 7,
  parameter int DATA_W = 32
) (
  input  logic [SEQ_W-1:0]  i_seq,
  input  logic [POS_W-1:0]  i_first,
  input  logic [POS_W-1:0]  i_last,
  input  logic              i_final,
  output logic [DATA_W-1:0] o_entry
);

  localparam int FIRST_LSB = first_lsb(POS_W);
  localparam int SEQ_LSB   = seq_lsb(POS_W);

  always_comb begin
    o_entry                       = '0;
    o_entry[FINAL_BIT]            = i_final;
    o_entry[LAST_LSB  +: POS_W]   = i_last;
    o_entry[FIRST_LSB +: POS_W]   = i_first;
    o_entry[SEQ_LSB   +: SEQ_W]   = i_seq;
  end

endmodule

// File: rtl/taglist_gen_p.sv
// Tag-list generator: scans end-marker codes, tracks element positions and
// writes one packed {seq, first, last, final} entry per completed sequence.
module taglist_gen_p
  import taglist_pkg::*;
#(
  parameter int POS_W  = 10,
  parameter int SEQ_W  = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk_1KHz,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        last_end,
  output logic              ram_we,
  output logic [SEQ_W-1:0]  ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic [SEQ_W:0]    entry_count,
  output logic              done,
  output logic              overflow,
  output logic              full
);

  if (DATA_W < entry_w(POS_W, SEQ_W)) begin : g_bad_width
    $error("taglist_gen_p: DATA_W too small for SEQ_W+2*POS_W+1");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [POS_W-1:0]    r_pos;
  logic [POS_W-1:0]    r_first;
  logic [SEQ_W-1:0]    r_seq;
  logic                r_final;
  logic                r_ram_we;
  logic [SEQ_W-1:0]    r_ram_addr;
  logic [DATA_W-1:0]   r_ram_data;
  logic [SEQ_W:0]      r_cnt;
  logic                r_overflow;
  logic                r_full;
  logic                w_accept;
  logic                w_pos_max;
  logic                w_seq_max;
  logic [DATA_W-1:0]   w_entry;

  assign w_accept  = in_valid && (r_state == ST_SCAN);
  assign w_pos_max = &r_pos;
  assign w_seq_max = &r_seq;

  taglist_entry_pack #(
    .POS_W  (POS_W),
    .SEQ_W  (SEQ_W),
    .DATA_W (DATA_W)
  ) u_pack (
    .i_seq   (r_seq),
    .i_first (r_first),
    .i_last  (r_pos),
    .i_final (last_end[0]),
    .o_entry (w_entry)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SCAN: begin
        if (w_accept) begin
          if (last_end[1])
            w_state_nxt = ST_WRITE;
          else if (last_end == LE_ELEM && w_pos_max)
            w_state_nxt = ST_DONE;
        end
      end
      // A completed ROM wins over full/overflow: it still ends in DONE but flags stay clear.
      ST_WRITE: begin
        if (r_final || w_seq_max || w_pos_max)
          w_state_nxt = ST_DONE;
        else
          w_state_nxt = ST_SCAN;
      end
      ST_DONE: begin
        if (start)
          w_state_nxt = ST_SCAN;
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk_1KHz) begin
    if (reset) begin
      r_state <= ST_SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_1KHz) begin
    if (reset) begin
      r_pos      <= '0;
      r_first    <= '0;
      r_seq      <= '0;
      r_final    <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      r_full     <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (w_accept) begin
            case (last_end)
              LE_ELEM: begin
                if (w_pos_max)
                  r_overflow <= 1'b1;
                else
                  r_pos <= r_pos + 1'b1;
              end
              LE_SKIP: ;
              default: begin
                r_ram_data <= w_entry;
                r_ram_addr <= r_seq;
                r_ram_we   <= 1'b1;
                r_final    <= last_end[0];
              end
            endcase
          end
        end
        ST_WRITE: begin
          r_cnt <= r_cnt + 1'b1;
          r_seq <= r_seq + 1'b1;
          if (!r_final) begin
            if (w_seq_max) begin
              r_full <= 1'b1;
            end else if (w_pos_max) begin
              r_overflow <= 1'b1;
            end else begin
              r_first <= r_pos + 1'b1;
              r_pos   <= r_pos + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            r_pos      <= '0;
            r_first    <= '0;
            r_seq      <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_full     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_SCAN);
  assign done        = (r_state == ST_DONE);
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_data    = r_ram_data;
  assign entry_count = r_cnt;
  assign overflow    = r_overflow;
  assign full        = r_full;

endmodule

// File: tb/tb_taglist_gen_p.sv
// Bench for taglist_gen_p: directed scenarios plus randomized streams checked
// against a sequence-level reference model, on a default and a small instance.
module tb_taglist_gen_p;
  import taglist_pkg::*;

  localparam int DPW = 10, DSW = 7, DDW = 32;
  localparam int SPW = 3,  SSW = 2, SDW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           d_reset, d_start, d_in_valid, d_in_ready, d_ram_we, d_done, d_overflow, d_full;
  logic [1:0]     d_last_end;
  logic [DSW-1:0] d_ram_addr;
  logic [DDW-1:0] d_ram_data;
  logic [DSW:0]   d_entry_count;

  logic           s_reset, s_start, s_in_valid, s_in_ready, s_ram_we, s_done, s_overflow, s_full;
  logic [1:0]     s_last_end;
  logic [SSW-1:0] s_ram_addr;
  logic [SDW-1:0] s_ram_data;
  logic [SSW:0]   s_entry_count;

  taglist_gen_p #(.POS_W(DPW), .SEQ_W(DSW), .DATA_W(DDW)) dut_d (
    .clk_1KHz(clk), .reset(d_reset), .start(d_start), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .last_end(d_last_end), .ram_we(d_ram_we),
    .ram_addr(d_ram_addr), .ram_data(d_ram_data), .entry_count(d_entry_count),
    .done(d_done), .overflow(d_overflow), .full(d_full));

  taglist_gen_p #(.POS_W(SPW), .SEQ_W(SSW), .DATA_W(SDW)) dut_s (
    .clk_1KHz(clk), .reset(s_reset), .start(s_start), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .last_end(s_last_end), .ram_we(s_ram_we),
    .ram_addr(s_ram_addr), .ram_data(s_ram_data), .entry_count(s_entry_count),
    .done(s_done), .overflow(s_overflow), .full(s_full));

  int total = 0;
  int passed = 0;

  logic [31:0] wa_d[$], wd_d[$], wa_s[$], wd_s[$];
  logic [31:0] obs_a[$], obs_d[$], exp_a[$], exp_d[$];
  logic [1:0]  beats[$];
  bit          m_over, m_full, m_done;

  // Write monitor: records every RAM write seen away from the active edge.
  always @(negedge clk) begin
    if (d_ram_we) begin wa_d.push_back(32'(d_ram_addr)); wd_d.push_back(32'(d_ram_data)); end
    if (s_ram_we) begin wa_s.push_back(32'(s_ram_addr)); wd_s.push_back(32'(s_ram_data)); end
  end

  task automatic clear_q();
    wa_d.delete(); wd_d.delete(); wa_s.delete(); wd_s.delete();
  endtask

  task automatic do_reset(input bit sm);
    @(negedge clk);
    if (sm) begin s_reset = 1; s_in_valid = 0; s_start = 0; end
    else    begin d_reset = 1; d_in_valid = 0; d_start = 0; end
    @(negedge clk);
    if (sm) s_reset = 0; else d_reset = 0;
  endtask

  task automatic pulse_start(input bit sm);
    @(negedge clk);
    if (sm) s_start = 1; else d_start = 1;
    @(negedge clk);
    if (sm) s_start = 0; else d_start = 0;
  endtask

  // Offers each queued beat until accepted; gives up once the block reports done.
  task automatic run_beats(input bit sm, input bit gaps);
    int  k;
    bit  stop;
    stop = 0;
    foreach (beats[i]) begin
      if (stop) break;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          if (sm) s_in_valid = 0; else d_in_valid = 0;
        end
      end
      k = 0;
      forever begin
        @(negedge clk);
        if (sm ? s_done : d_done) begin stop = 1; break; end
        if (sm) begin s_in_valid = 1; s_last_end = beats[i]; end
        else    begin d_in_valid = 1; d_last_end = beats[i]; end
        if (sm ? s_in_ready : d_in_ready) begin @(posedge clk); break; end
        k++;
        if (k > 20) begin
          total++;
          $display("FAIL beat_timeout: beat %0d not accepted within 20 cycles, want accepted", i);
          stop = 1;
          break;
        end
      end
    end
    @(negedge clk);
    if (sm) s_in_valid = 0; else d_in_valid = 0;
  endtask

  // Sequence-level model: elements are numbered in order, skips are invisible,
  // each end marker closes a sequence running from the previous boundary.
  task automatic model(input int pw, input int sw);
    int idx, first, seq, pmax, smax;
    exp_a.delete(); exp_d.delete();
    m_over = 0; m_full = 0; m_done = 0;
    idx = 0; first = 0; seq = 0;
    pmax = (1 << pw) - 1; smax = (1 << sw) - 1;
    foreach (beats[i]) begin
      if (beats[i] == LE_SKIP) continue;
      if (beats[i] == LE_ELEM) begin
        if (idx == pmax) begin m_over = 1; m_done = 1; break; end
        idx++;
        continue;
      end
      exp_a.push_back(32'(seq));
      exp_d.push_back(32'((seq << seq_lsb(pw)) | (first << first_lsb(pw)) |
                          (idx << LAST_LSB) | (beats[i] == LE_ROM_END ? 1 : 0)));
      if (beats[i] == LE_ROM_END) begin m_done = 1; break; end
      if (seq == smax) begin m_full = 1; m_done = 1; break; end
      if (idx == pmax) begin m_over = 1; m_done = 1; break; end
      seq++; idx++; first = idx;
    end
  endtask

  task automatic test_reset();
    do_reset(0);
    do_reset(1);
    total++; if (d_ram_we !== 1'b0) $display("FAIL rst_we: got %0b want 0", d_ram_we); else passed++;
    total++; if (d_ram_addr !== '0) $display("FAIL rst_addr: got %0h want 0", d_ram_addr); else passed++;
    total++; if (d_ram_data !== '0) $display("FAIL rst_data: got %0h want 0", d_ram_data); else passed++;
    total++; if (d_entry_count !== '0) $display("FAIL rst_cnt: got %0d want 0", d_entry_count); else passed++;
    total++; if ({d_done, d_overflow, d_full} !== 3'b000)
      $display("FAIL rst_flags: got %03b want 000", {d_done, d_overflow, d_full}); else passed++;
    total++; if (d_in_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", d_in_ready); else passed++;
    total++; if (s_in_ready !== 1'b1) $display("FAIL rst_ready_s: got %0b want 1", s_in_ready); else passed++;
  endtask

  task automatic test_two_entries();
    do_reset(0); clear_q();
    beats = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b11};
    run_beats(0, 0);
    repeat (3) @(negedge clk);
    total++; if (wd_d.size() != 2) $display("FAIL two_nwr: got %0d want 2", wd_d.size()); else passed++;
    if (wd_d.size() >= 2) begin
      total++; if (wa_d[0] !== 32'd0) $display("FAIL two_addr0: got %0h want 0", wa_d[0]); else passed++;
      total++; if (wd_d[0] !== 32'h0000_0004) $display("FAIL two_data0: got %0h want 4", wd_d[0]); else passed++;
      total++; if (wa_d[1] !== 32'd1) $display("FAIL two_addr1: got %0h want 1", wa_d[1]); else passed++;
      total++; if (wd_d[1] !== 32'h0020_1809) $display("FAIL two_data1: got %0h want 201809", wd_d[1]); else passed++;
    end
    total++; if (d_done !== 1'b1) $display("FAIL two_done: got %0b want 1", d_done); else passed++;
    total++; if (d_entry_count !== 8'd2) $display("FAIL two_cnt: got %0d want 2", d_entry_count); else passed++;
    total++; if (d_in_ready !== 1'b0) $display("FAIL two_ready: got %0b want 0", d_in_ready); else passed++;
  endtask

  task automatic test_restart();
    clear_q();
    pulse_start(0);
    total++; if (d_in_ready !== 1'b1) $display("FAIL rs_ready: got %0b want 1", d_in_ready); else passed++;
    total++; if ({d_done, d_overflow, d_full} !== 3'b000)
      $display("FAIL rs_flags: got %03b want 000", {d_done, d_overflow, d_full}); else passed++;
    total++; if (d_entry_count !== '0) $display("FAIL rs_cnt: got %0d want 0", d_entry_count); else passed++;
    beats = '{2'b00, 2'b11, 2'b10, 2'b10};
    run_beats(0, 0);
    @(negedge clk); d_in_valid = 1; d_last_end = 2'b10;
    repeat (4) @(negedge clk);
    d_in_valid = 0;
    repeat (2) @(negedge clk);
    total++; if (wd_d.size() != 1) $display("FAIL rs_nwr: got %0d want 1", wd_d.size()); else passed++;
    if (wd_d.size() >= 1) begin
      total++; if (wa_d[0] !== 32'd0) $display("FAIL rs_addr: got %0h want 0", wa_d[0]); else passed++;
      total++; if (wd_d[0] !== 32'h0000_0003) $display("FAIL rs_data: got %0h want 3", wd_d[0]); else passed++;
    end
    total++; if (d_done !== 1'b1) $display("FAIL rs_done: got %0b want 1", d_done); else passed++;
    total++; if (d_entry_count !== 8'd1) $display("FAIL rs_cnt1: got %0d want 1", d_entry_count); else passed++;
  endtask

  task automatic test_skip();
    clear_q();
    pulse_start(0);
    beats = '{2'b00, 2'b01, 2'b01, 2'b10};
    run_beats(0, 1);
    repeat (3) @(negedge clk);
    total++; if (wd_d.size() != 1) $display("FAIL skip_nwr: got %0d want 1", wd_d.size()); else passed++;
    if (wd_d.size() >= 1) begin
      total++; if (wd_d[0] !== 32'h0000_0002) $display("FAIL skip_data: got %0h want 2", wd_d[0]); else passed++;
    end
    total++; if (d_in_ready !== 1'b1) $display("FAIL skip_ready: got %0b want 1", d_in_ready); else passed++;
    total++; if (d_entry_count !== 8'd1) $display("FAIL skip_cnt: got %0d want 1", d_entry_count); else passed++;
  endtask

  task automatic test_reset_collision();
    clear_q();
    @(negedge clk); d_reset = 1; d_in_valid = 1; d_last_end = 2'b10;
    @(negedge clk); d_reset = 0; d_in_valid = 0;
    total++; if (d_ram_we !== 1'b0) $display("FAIL col_we: got %0b want 0", d_ram_we); else passed++;
    total++; if (d_ram_data !== '0 || d_ram_addr !== '0)
      $display("FAIL col_out: got addr %0h data %0h want 0 0", d_ram_addr, d_ram_data); else passed++;
    total++; if (d_entry_count !== '0) $display("FAIL col_cnt: got %0d want 0", d_entry_count); else passed++;
    total++; if (d_in_ready !== 1'b1) $display("FAIL col_ready: got %0b want 1", d_in_ready); else passed++;
    beats = '{2'b10};
    run_beats(0, 0);
    repeat (3) @(negedge clk);
    total++; if (wd_d.size() != 1) $display("FAIL col_nwr: got %0d want 1", wd_d.size()); else passed++;
    if (wd_d.size() >= 1) begin
      total++; if (wa_d[0] !== 32'd0 || wd_d[0] !== 32'd0)
        $display("FAIL col_entry: got addr %0h data %0h want 0 0", wa_d[0], wd_d[0]); else passed++;
    end
  endtask

  task automatic test_overflow();
    do_reset(1); clear_q();
    beats.delete();
    repeat (8) beats.push_back(2'b00);
    run_beats(1, 0);
    repeat (3) @(negedge clk);
    total++; if (wd_s.size() != 0) $display("FAIL ovf_nwr: got %0d want 0", wd_s.size()); else passed++;
    total++; if ({s_done, s_overflow, s_full} !== 3'b110)
      $display("FAIL ovf_flags: got %03b want 110", {s_done, s_overflow, s_full}); else passed++;
    total++; if (s_in_ready !== 1'b0) $display("FAIL ovf_ready: got %0b want 0", s_in_ready); else passed++;
  endtask

  task automatic test_overflow_after_write();
    do_reset(1); clear_q();
    beats.delete();
    repeat (7) beats.push_back(2'b00);
    beats.push_back(2'b10);
    run_beats(1, 0);
    repeat (3) @(negedge clk);
    total++; if (wd_s.size() != 1) $display("FAIL ovw_nwr: got %0d want 1", wd_s.size()); else passed++;
    if (wd_s.size() >= 1) begin
      total++; if (wd_s[0] !== 32'h0000_000E) $display("FAIL ovw_data: got %0h want e", wd_s[0]); else passed++;
    end
    total++; if ({s_done, s_overflow, s_full} !== 3'b110)
      $display("FAIL ovw_flags: got %03b want 110", {s_done, s_overflow, s_full}); else passed++;
    total++; if (s_entry_count !== 3'd1) $display("FAIL ovw_cnt: got %0d want 1", s_entry_count); else passed++;
  endtask

  task automatic test_full();
    do_reset(1); clear_q();
    beats = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    run_beats(1, 0);
    repeat (3) @(negedge clk);
    total++; if (wd_s.size() != 4) $display("FAIL full_nwr: got %0d want 4", wd_s.size()); else passed++;
    for (int i = 0; i < 4 && i < wd_s.size(); i++) begin
      total++;
      if (wa_s[i] !== 32'(i) || wd_s[i] !== 32'((i << 7) | (i << 4) | (i << 1)))
        $display("FAIL full_entry%0d: got addr %0h data %0h want addr %0h data %0h",
                 i, wa_s[i], wd_s[i], i, (i << 7) | (i << 4) | (i << 1));
      else passed++;
    end
    total++; if ({s_done, s_overflow, s_full} !== 3'b101)
      $display("FAIL full_flags: got %03b want 101", {s_done, s_overflow, s_full}); else passed++;
    total++; if (s_entry_count !== 3'd4) $display("FAIL full_cnt: got %0d want 4", s_entry_count); else passed++;
  endtask

  task automatic test_random(input bit sm, input int rounds);
    int x, n;
    for (int r = 0; r < rounds; r++) begin
      do_reset(sm); clear_q();
      beats.delete();
      n = $urandom_range(5, 40);
      for (int i = 0; i < n; i++) begin
        x = $urandom_range(0, 99);
        beats.push_back(x < 55 ? 2'b00 : x < 70 ? 2'b01 : x < 92 ? 2'b10 : 2'b11);
      end
      run_beats(sm, 1);
      repeat (3) @(negedge clk);
      if (sm) begin model(SPW, SSW); obs_a = wa_s; obs_d = wd_s; end
      else    begin model(DPW, DSW); obs_a = wa_d; obs_d = wd_d; end
      total++; if (obs_d.size() != exp_d.size())
        $display("FAIL rnd%0d_%0d_nwr: got %0d want %0d", sm, r, obs_d.size(), exp_d.size()); else passed++;
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
        total++;
        if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i])
          $display("FAIL rnd%0d_%0d_entry%0d: got addr %0h data %0h want addr %0h data %0h",
                   sm, r, i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
        else passed++;
      end
      total++;
      if ((sm ? {s_done, s_overflow, s_full} : {d_done, d_overflow, d_full}) !== {m_done, m_over, m_full})
        $display("FAIL rnd%0d_%0d_flags: got %03b want %03b", sm, r,
                 sm ? {s_done, s_overflow, s_full} : {d_done, d_overflow, d_full}, {m_done, m_over, m_full});
      else passed++;
      total++;
      if ((sm ? int'(s_entry_count) : int'(d_entry_count)) != exp_d.size())
        $display("FAIL rnd%0d_%0d_cnt: got %0d want %0d", sm, r,
                 sm ? int'(s_entry_count) : int'(d_entry_count), exp_d.size());
      else passed++;
    end
  endtask

  initial begin
    d_reset = 1; d_start = 0; d_in_valid = 0; d_last_end = 2'b00;
    s_reset = 1; s_start = 0; s_in_valid = 0; s_last_end = 2'b00;
    repeat (2) @(negedge clk);
    test_reset();
    test_two_entries();
    test_restart();
    test_skip();
    test_reset_collision();
    test_overflow();
    test_overflow_after_write();
    test_full();
    test_random(0, 8);
    test_random(1, 12);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
